wb_burst_traffic_gen: RTL and testbench

// - Synthesisable Wishbone B4 burst master. It replaces the hand-driven wb_* stimulus at the SDRAM controller's Wishbone port.
// - Writes N incrementing bursts of a regenerable data pattern, then reads them all back and compares.
// - Reports busy/done, the error count, the first failing address and a timeout flag.
// - Sits between the test/BIST control and the sdrc_top Wishbone slave port, in the sys_clk domain.

---
 rtl/wb_burst_traffic_gen_if.sv | 25 ++
 rtl/wb_burst_traffic_gen.sv | 211 +++++++++++++++++++++
 tb/tb_wb_burst_traffic_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_traffic_gen_if.sv
// rtl/wb_burst_traffic_gen_if.sv - Wishbone B4 burst bus between the traffic generator and a slave port.
interface wb_burst_traffic_gen_if #(
  parameter int dw     = 32,
  parameter int APP_AW = 26
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic [dw-1:0]     wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_burst_traffic_gen.sv
// rtl/wb_burst_traffic_gen.sv - Wishbone burst master: writes N bursts of a pattern, reads them back and compares.
module wb_burst_traffic_gen #(
  parameter int dw        = 32,
  parameter int APP_AW    = 26,
  parameter int BURST_MAX = 8,
  parameter int NB_W      = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         start,
  input  logic [APP_AW-1:0]            base_addr,
  input  logic [NB_W-1:0]              num_bursts,
  input  logic [$clog2(BURST_MAX):0]   burst_len,
  input  logic [1:0]                   pat_mode,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  err_count,
  output logic [APP_AW-1:0]            err_addr,
  output logic                         timeout,
  wb_burst_traffic_gen_if.master       wb
);

  localparam int BLW = $clog2(BURST_MAX) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [APP_AW-1:0] STEP = APP_AW'(dw / 8);

  typedef enum logic [2:0] {IDLE, WR_BEAT, WR_GAP, RD_BEAT, RD_GAP, FIN} state_t;

  state_t            state;
  logic [APP_AW-1:0] base_q;
  logic [NB_W-1:0]   nb_q;
  logic [NB_W-1:0]   burst_q;
  logic [BLW-1:0]    blen_q;
  logic [BLW-1:0]    beat_q;
  logic [1:0]        mode_q;
  logic [WDW-1:0]    wdog_q;

  logic [BLW-1:0]    blen_in;
  logic [dw-1:0]     exp_dat;
  logic [APP_AW-1:0] next_addr;
  logic              last_beat;
  logic              ack;

  // Pure function of address, beat index and mode so the read phase can regenerate it.
  function automatic logic [dw-1:0] pattern(input logic [APP_AW-1:0] a,
                                            input logic [BLW-1:0] beat,
                                            input logic [1:0] m);
    logic [dw-1:0]     p;
    logic [APP_AW-1:0] na;
    p  = '0;
    na = ~a;
    case (m)
      2'b00:   p = dw'(a);
      2'b01:   p = dw'(na);
      2'b10:   p = dw'(1) << (int'(beat) % dw);
      default: p = {(dw/8){8'h5A}};
    endcase
    return p;
  endfunction

  function automatic logic [2:0] cti_for(input logic [BLW-1:0] beat, input logic [BLW-1:0] blen);
    if (blen == BLW'(1))             return 3'b000;
    else if (beat == blen - 1'b1)    return 3'b111;
    else                             return 3'b010;
  endfunction

  always_comb begin
    blen_in = burst_len;
    if (burst_len == '0)
      blen_in = BLW'(1);
    else if (burst_len > BLW'(BURST_MAX))
      blen_in = BLW'(BURST_MAX);
  end

  assign exp_dat   = pattern(wb.wb_addr_o, beat_q, mode_q);
  assign next_addr = wb.wb_addr_o + STEP;
  assign last_beat = (beat_q == blen_q - 1'b1);
  assign ack       = wb.wb_stb_o & wb.wb_ack_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      base_q       <= '0;
      nb_q         <= '0;
      burst_q      <= '0;
      blen_q       <= '0;
      beat_q       <= '0;
      mode_q       <= '0;
      wdog_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_count    <= '0;
      err_addr     <= '0;
      timeout      <= 1'b0;
      wb.wb_cyc_o  <= 1'b0;
      wb.wb_stb_o  <= 1'b0;
      wb.wb_we_o   <= 1'b0;
      wb.wb_addr_o <= '0;
      wb.wb_dat_o  <= '0;
      wb.wb_sel_o  <= '0;
      wb.wb_cti_o  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            nb_q      <= num_bursts;
            blen_q    <= blen_in;
            mode_q    <= pat_mode;
            beat_q    <= '0;
            burst_q   <= '0;
            wdog_q    <= '0;
            err_count <= '0;
            err_addr  <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            if (num_bursts == '0) begin
              state <= FIN;
            end else begin
              state        <= WR_BEAT;
              wb.wb_cyc_o  <= 1'b1;
              wb.wb_stb_o  <= 1'b1;
              wb.wb_we_o   <= 1'b1;
              wb.wb_addr_o <= base_addr;
              wb.wb_dat_o  <= pattern(base_addr, '0, pat_mode);
              wb.wb_sel_o  <= '1;
              wb.wb_cti_o  <= cti_for('0, blen_in);
            end
          end
        end

        WR_BEAT, RD_BEAT: begin
          if (ack) begin
            wdog_q       <= '0;
            wb.wb_addr_o <= next_addr;
            if (state == RD_BEAT && wb.wb_dat_i != exp_dat) begin
              if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
              if (err_count == 16'd0)
                err_addr <= wb.wb_addr_o;
            end
            if (last_beat) begin
              wb.wb_cyc_o <= 1'b0;
              wb.wb_stb_o <= 1'b0;
              wb.wb_sel_o <= '0;
              wb.wb_cti_o <= '0;
              wb.wb_dat_o <= '0;
              beat_q      <= '0;
              burst_q     <= burst_q + 1'b1;
              state       <= (state == WR_BEAT) ? WR_GAP : RD_GAP;
            end else begin
              beat_q      <= beat_q + 1'b1;
              wb.wb_cti_o <= cti_for(beat_q + 1'b1, blen_q);
              if (state == WR_BEAT)
                wb.wb_dat_o <= pattern(next_addr, beat_q + 1'b1, mode_q);
            end
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            // Slave is stuck: abandon the run, skipping any remaining bursts.
            timeout     <= 1'b1;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_sel_o <= '0;
            wb.wb_cti_o <= '0;
            wb.wb_dat_o <= '0;
            state       <= FIN;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        WR_GAP, RD_GAP: begin
          wdog_q <= '0;
          if (burst_q != nb_q) begin
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_sel_o <= '1;
            wb.wb_cti_o <= cti_for('0, blen_q);
            if (state == WR_GAP)
              wb.wb_dat_o <= pattern(wb.wb_addr_o, '0, mode_q);
            state <= (state == WR_GAP) ? WR_BEAT : RD_BEAT;
          end else if (state == WR_GAP) begin
            burst_q      <= '0;
            wb.wb_addr_o <= base_q;
            wb.wb_we_o   <= 1'b0;
            wb.wb_cyc_o  <= 1'b1;
            wb.wb_stb_o  <= 1'b1;
            wb.wb_sel_o  <= '1;
            wb.wb_cti_o  <= cti_for('0, blen_q);
            state        <= RD_BEAT;
          end else begin
            state <= FIN;
          end
        end

        FIN: begin
          done         <= 1'b1;
          busy         <= 1'b0;
          wb.wb_we_o   <= 1'b0;
          wb.wb_addr_o <= '0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_traffic_gen.sv
// tb/tb_wb_burst_traffic_gen.sv - Table-driven bench for wb_burst_traffic_gen with a zero-wait memory slave.
module tb_wb_burst_traffic_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [25:0] base_addr = '0;
  logic [15:0] num_bursts = '0;
  logic [3:0]  burst_len = '0;
  logic [1:0]  pat_mode = '0;
  logic        busy, done, timeout;
  logic [15:0] err_count;
  logic [25:0] err_addr;

  logic        ack_en = 1'b1;
  logic        corrupt_en = 1'b0;
  logic [25:0] bad_addr = '0;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int start_stamp;

  always #5 clk = ~clk;

  wb_burst_traffic_gen_if #(.dw(32), .APP_AW(26)) wb ();

  wb_burst_traffic_gen #(
    .dw(32), .APP_AW(26), .BURST_MAX(8), .NB_W(16), .TIMEOUT(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .burst_len(burst_len), .pat_mode(pat_mode),
    .busy(busy), .done(done), .err_count(err_count), .err_addr(err_addr),
    .timeout(timeout), .wb(wb)
  );

  assign wb.wb_ack_i = ack_en & wb.wb_stb_o;
  always_comb
    wb.wb_dat_i = mem[wb.wb_addr_o[11:2]] ^
                  ((corrupt_en && wb.wb_addr_o == bad_addr) ? 32'h1 : 32'h0);

  always @(posedge clk) begin
    cnt <= cnt + 1;
    if (wb.wb_stb_o && wb.wb_ack_i && wb.wb_we_o)
      mem[wb.wb_addr_o[11:2]] <= wb.wb_dat_o;
  end

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic [3:0]  sel;
    int          stamp;
  } beat_t;

  beat_t log_q[$];
  int    done_cnt = 0, done_stamp = 0, stb_cycles = 0, to_stamp = 0;
  logic  to_prev = 1'b0, cyc_at_to = 1'b1, busy_at_done = 1'b1;

  always @(negedge clk) begin
    if (wb.wb_stb_o && wb.wb_ack_i)
      log_q.push_back('{wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o, wb.wb_cti_o, wb.wb_sel_o, cnt});
    if (wb.wb_stb_o)
      stb_cycles <= stb_cycles + 1;
    if (done) begin
      done_cnt     <= done_cnt + 1;
      done_stamp   <= cnt;
      busy_at_done <= busy;
    end
    to_prev <= timeout;
    if (timeout && !to_prev) begin
      to_stamp  <= cnt;
      cyc_at_to <= wb.wb_cyc_o;
    end
  end

  typedef struct {
    logic [25:0] base;
    logic [15:0] nb;
    logic [3:0]  blen;
    logic [1:0]  mode;
    logic        corrupt;
    logic [25:0] bad;
    logic        poke;
    int          exp_beats;
    logic [15:0] exp_err;
    logic [25:0] exp_err_addr;
    logic [31:0] exp_first_dat;
    logic [25:0] exp_last_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pat(input logic [25:0] a, input int beat, input logic [1:0] m);
    case (m)
      2'd0:    return {6'b0, a};
      2'd1:    return {6'b0, ~a};
      2'd2:    return 32'h1 << (beat % 32);
      default: return 32'h5A5A5A5A;
    endcase
  endfunction

  function automatic int eff_len(input logic [3:0] b);
    if (b == 0) return 1;
    if (b > 8)  return 8;
    return int'(b);
  endfunction

  task automatic wait_done(input int base_done);
    int t = 0;
    while (done_cnt == base_done && t < 400) begin
      @(posedge clk);
      t++;
    end
  endtask

  task automatic kick(input logic [25:0] b, input logic [15:0] n, input logic [3:0] l, input logic [1:0] m);
    @(negedge clk);
    log_q.delete();
    start_stamp = cnt;
    base_addr   = b;
    num_bursts  = n;
    burst_len   = l;
    pat_mode    = m;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          be, per_phase, nbeats, bad, base_done, k, j, exp_lat;
    logic [25:0] ea;
    logic [2:0]  ecti;
    ack_en     = 1'b1;
    corrupt_en = v.corrupt;
    bad_addr   = v.bad;
    base_done  = done_cnt;
    kick(v.base, v.nb, v.blen, v.mode);
    if (v.poke) begin
      base_addr = 26'h0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(base_done);
    repeat (4) @(negedge clk);

    be        = eff_len(v.blen);
    per_phase = int'(v.nb) * be;
    nbeats    = 2 * per_phase;
    check($sformatf("v%0d_n_beats", id), log_q.size(), v.exp_beats);
    bad = 0;
    for (int i = 0; i < log_q.size() && i < nbeats; i++) begin
      j    = i % per_phase;
      k    = j % be;
      ea   = v.base + 26'(4 * j);
      ecti = (be == 1) ? 3'b000 : (k == be - 1) ? 3'b111 : 3'b010;
      if (log_q[i].we != (i < per_phase) || log_q[i].addr != ea ||
          log_q[i].cti != ecti || log_q[i].sel != 4'hF)
        bad++;
      if (i < per_phase && log_q[i].dat != model_pat(ea, k, v.mode))
        bad++;
      if (i == 0) begin
        if (log_q[0].stamp - start_stamp != 1) bad++;
      end else if (log_q[i].stamp - log_q[i-1].stamp != ((k == 0) ? 2 : 1)) begin
        bad++;
      end
    end
    check($sformatf("v%0d_beat_seq", id), bad, 0);
    if (log_q.size() > 0 && per_phase > 0 && log_q.size() >= per_phase) begin
      check($sformatf("v%0d_first_dat", id), log_q[0].dat, v.exp_first_dat);
      check($sformatf("v%0d_last_wr_addr", id), log_q[per_phase-1].addr, v.exp_last_addr);
    end
    check($sformatf("v%0d_done_count", id), done_cnt - base_done, 1);
    exp_lat = (log_q.size() > 0) ? log_q[log_q.size()-1].stamp + 3 : start_stamp + 2;
    check($sformatf("v%0d_done_time", id), done_stamp, exp_lat);
    check($sformatf("v%0d_err_count", id), err_count, v.exp_err);
    check($sformatf("v%0d_err_addr", id), err_addr, v.exp_err_addr);
    check($sformatf("v%0d_idle", id), {busy, timeout, busy_at_done, wb.wb_cyc_o}, 4'b0);
    corrupt_en = 1'b0;
  endtask

  initial begin
    int   base_done, base_stb, t;
    logic reached;

    vecs[0] = '{26'h100,     16'd2, 4'd4,  2'd0, 1'b0, 26'h0,   1'b0, 16, 16'd0, 26'h0,   32'h00000100, 26'h11C};
    vecs[1] = '{26'h100,     16'd2, 4'd4,  2'd0, 1'b1, 26'h108, 1'b0, 16, 16'd1, 26'h108, 32'h00000100, 26'h11C};
    vecs[2] = '{26'h200,     16'd3, 4'd1,  2'd3, 1'b0, 26'h0,   1'b0, 6,  16'd0, 26'h0,   32'h5A5A5A5A, 26'h208};
    vecs[3] = '{26'h40,      16'd1, 4'd2,  2'd1, 1'b0, 26'h0,   1'b0, 4,  16'd0, 26'h0,   32'h03FFFFBF, 26'h44};
    vecs[4] = '{26'h0,       16'd1, 4'd15, 2'd2, 1'b0, 26'h0,   1'b0, 16, 16'd0, 26'h0,   32'h00000001, 26'h1C};
    vecs[5] = '{26'h10,      16'd2, 4'd0,  2'd0, 1'b0, 26'h0,   1'b0, 4,  16'd0, 26'h0,   32'h00000010, 26'h14};
    vecs[6] = '{26'h3FFFFF8, 16'd1, 4'd4,  2'd0, 1'b0, 26'h0,   1'b1, 8,  16'd0, 26'h0,   32'h03FFFFF8, 26'h4};
    vecs[7] = '{26'h300,     16'd0, 4'd4,  2'd0, 1'b0, 26'h0,   1'b0, 0,  16'd0, 26'h0,   32'h0,        26'h0};

    repeat (2) @(negedge clk);
    check("reset_outputs", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o,
                            wb.wb_sel_o, wb.wb_cti_o, busy, done, err_count, err_addr, timeout}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, done, wb.wb_cyc_o, timeout}, 4'b0);

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], i);

    // Slave that never acknowledges.
    ack_en    = 1'b0;
    base_done = done_cnt;
    base_stb  = stb_cycles;
    kick(26'h0, 16'd2, 4'd4, 2'd0);
    wait_done(base_done);
    repeat (3) @(negedge clk);
    check("to_stb_cycles", stb_cycles - base_stb, 16);
    check("to_flag", timeout, 1'b1);
    check("to_time", to_stamp - start_stamp, 17);
    check("to_cyc_dropped", cyc_at_to, 1'b0);
    check("to_done_count", done_cnt - base_done, 1);
    check("to_done_time", done_stamp - start_stamp, 18);
    check("to_busy", {busy, busy_at_done}, 2'b0);
    check("to_no_acks", log_q.size(), 0);
    ack_en = 1'b1;

    // Reset in the middle of a read burst, then a clean rerun.
    kick(26'h100, 16'd2, 4'd4, 2'd0);
    reached = 1'b0;
    t = 0;
    while (!reached && t < 100) begin
      @(negedge clk);
      reached = wb.wb_stb_o && !wb.wb_we_o;
      t++;
    end
    check("rst_read_phase_reached", reached, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o,
                                wb.wb_sel_o, wb.wb_cti_o, busy, done, err_count, err_addr, timeout}, '0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
